// File: rtl/amm_arbiter_if.sv
// Avalon-MM bundle shared by the arbiter's master ports and its slave port.
interface avalon_mm_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   address;
  logic                read;
  logic                write;
  logic [DATA_W-1:0]   writedata;
  logic [DATA_W/8-1:0] byteenable;
  logic [DATA_W-1:0]   readdata;
  logic                readdatavalid;
  logic                waitrequest;

  modport master (
    output address, read, write, writedata, byteenable,
    input  readdata, readdatavalid, waitrequest
  );

  modport slave (
    input  address, read, write, writedata, byteenable,
    output readdata, readdatavalid, waitrequest
  );
endinterface

// File: rtl/amm_arbiter.sv
// Round-robin Avalon-MM arbiter: MST_CNT masters share one slave port, one
// transaction at a time, with a forced zero response when a read never returns.
module amm_arbiter #(
  parameter int MST_CNT    = 2,
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 32,
  parameter int RD_TIMEOUT = 64
) (
  input  logic               clk_i,
  input  logic               rst_i,
  avalon_mm_if.slave         mst_mem_if [0:MST_CNT-1],
  avalon_mm_if.master        slv_mem_if,
  output logic [MST_CNT-1:0] grant_o,
  output logic               timeout_o,
  output logic               busy_o,
  output logic [1:0]         dbg_state_o
);
  localparam int IDX_W = $clog2(MST_CNT);
  localparam int CNT_W = $clog2(RD_TIMEOUT);
  localparam int BE_W  = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CMD     = 2'd1,
    RD_WAIT = 2'd2
  } state_e;

  // Handshake: a master command is accepted in the cycle its read or write is
  // high while its waitrequest is low; readdatavalid is a one-cycle strobe.
  state_e             state_q, state_d;
  logic [MST_CNT-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [ADDR_W-1:0]  m_addr  [MST_CNT];
  logic [DATA_W-1:0]  m_wdata [MST_CNT];
  logic [BE_W-1:0]    m_be    [MST_CNT];
  logic [MST_CNT-1:0] m_rd, m_wr, req;

  logic               pick_found;
  logic [IDX_W-1:0]   pick_idx;
  int                 scan_j;
  logic               in_cmd, fwd, tmo, rsp_vld;
  logic [DATA_W-1:0]  rsp_data;

  for (genvar g = 0; g < MST_CNT; g++) begin : g_mst
    assign m_addr[g]  = mst_mem_if[g].address;
    assign m_wdata[g] = mst_mem_if[g].writedata;
    assign m_be[g]    = mst_mem_if[g].byteenable;
    assign m_rd[g]    = mst_mem_if[g].read;
    assign m_wr[g]    = mst_mem_if[g].write;
    assign mst_mem_if[g].waitrequest   = (in_cmd && grant_q[g]) ? slv_mem_if.waitrequest : 1'b1;
    assign mst_mem_if[g].readdatavalid = rsp_vld && grant_q[g];
    assign mst_mem_if[g].readdata      = (rsp_vld && grant_q[g]) ? rsp_data : '0;
  end

  assign req    = m_rd | m_wr;
  assign in_cmd = (state_q == CMD);

  // last_q always names the granted master while a transaction is open.
  assign slv_mem_if.address    = m_addr[last_q];
  assign slv_mem_if.writedata  = m_wdata[last_q];
  assign slv_mem_if.byteenable = m_be[last_q];
  assign slv_mem_if.read       = in_cmd && m_rd[last_q];
  assign slv_mem_if.write      = in_cmd && m_wr[last_q];

  // Scan downward so the nearest requester after last_q is the final assignment.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = last_q;
    scan_j     = 0;
    for (int k = MST_CNT; k >= 1; k--) begin
      scan_j = (int'(last_q) + k) % MST_CNT;
      if (req[scan_j]) begin
        pick_found = 1'b1;
        pick_idx   = IDX_W'(scan_j);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    fwd     = 1'b0;
    tmo     = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d = MST_CNT'(1) << pick_idx;
          last_d  = pick_idx;
          state_d = CMD;
        end
      end
      CMD: begin
        if (!req[last_q]) begin
          state_d = IDLE;
          grant_d = '0;
        end else if (!slv_mem_if.waitrequest) begin
          if (m_rd[last_q]) begin
            state_d = RD_WAIT;
            cnt_d   = '0;
          end else begin
            state_d = IDLE;
            grant_d = '0;
          end
        end
      end
      RD_WAIT: begin
        if (slv_mem_if.readdatavalid) begin
          fwd     = 1'b1;
          state_d = IDLE;
          grant_d = '0;
        end else if (cnt_q == CNT_W'(RD_TIMEOUT - 1)) begin
          tmo     = 1'b1;
          state_d = IDLE;
          grant_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  assign rsp_vld  = fwd || tmo;
  assign rsp_data = fwd ? slv_mem_if.readdata : '0;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= IDX_W'(MST_CNT - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign grant_o     = grant_q;
  assign timeout_o   = tmo;
  assign busy_o      = (state_q != IDLE);
  assign dbg_state_o = state_q;
endmodule

// File: tb/tb_amm_arbiter.sv
// Bench for amm_arbiter: two masters, a behavioural slave, a response
// scoreboard and a round-robin grant model.
module tb_amm_arbiter;
  localparam int N  = 2;
  localparam int TO = 64;
  localparam int W  = 40;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  avalon_mm_if #(.ADDR_W(16), .DATA_W(32)) mst_if [0:N-1] ();
  avalon_mm_if #(.ADDR_W(16), .DATA_W(32)) slv_if ();

  logic [N-1:0] grant;
  logic         timeout, busy;
  logic [1:0]   dbg_state;

  amm_arbiter #(.MST_CNT(N), .ADDR_W(16), .DATA_W(32), .RD_TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_i(rst_n), .mst_mem_if(mst_if), .slv_mem_if(slv_if),
    .grant_o(grant), .timeout_o(timeout), .busy_o(busy), .dbg_state_o(dbg_state)
  );

  logic [N-1:0] m_read = '0, m_write = '0, m_wait, m_rdv;
  logic [15:0]  m_addr  [N];
  logic [31:0]  m_wdata [N];
  logic [31:0]  m_rdata [N];

  for (genvar g = 0; g < N; g++) begin : g_m
    assign mst_if[g].address    = m_addr[g];
    assign mst_if[g].read       = m_read[g];
    assign mst_if[g].write      = m_write[g];
    assign mst_if[g].writedata  = m_wdata[g];
    assign mst_if[g].byteenable = 4'hF;
    assign m_wait[g]  = mst_if[g].waitrequest;
    assign m_rdv[g]   = mst_if[g].readdatavalid;
    assign m_rdata[g] = mst_if[g].readdata;
  end

  int total = 0, bad = 0, cyc = 0, tmo_cnt = 0;
  int grants_cnt [N];
  logic [W-1:0] exp_q [$];
  logic [31:0]  model_mem [256];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Slave model: fixed stall per command, random read latency, drop and stray modes
  int          slv_stall = 0, slv_lat_min = 1, slv_lat_max = 1;
  bit          slv_drop = 0, slv_stray = 0;
  int          stall_cnt = 0, rd_cnt = 0;
  bit          rd_pend = 0;
  logic [31:0] rd_data = '0;
  logic [31:0] mem [256];

  assign slv_if.waitrequest   = (slv_if.read || slv_if.write) && (stall_cnt < slv_stall);
  assign slv_if.readdatavalid = (rd_pend && rd_cnt == 0) || slv_stray;
  assign slv_if.readdata      = slv_stray ? 32'hDEAD_BEEF : ((rd_pend && rd_cnt == 0) ? rd_data : 32'h0);

  always @(posedge clk) begin
    if (rd_pend) begin
      if (rd_cnt == 0) rd_pend <= 1'b0;
      else rd_cnt <= rd_cnt - 1;
    end
    if (slv_if.read || slv_if.write) begin
      if (stall_cnt < slv_stall) stall_cnt <= stall_cnt + 1;
      else begin
        stall_cnt <= 0;
        if (slv_if.write) mem[slv_if.address[7:0]] <= slv_if.writedata;
        else if (!slv_drop) begin
          rd_pend <= 1'b1;
          rd_cnt  <= int'($urandom_range(slv_lat_max, slv_lat_min)) - 1;
          rd_data <= mem[slv_if.address[7:0]];
        end
      end
    end else stall_cnt <= 0;
  end

  // Response monitor: every readdatavalid pops the scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      if (timeout) tmo_cnt++;
      for (int m = 0; m < N; m++) begin
        if (m_rdv[m]) begin
          if (exp_q.size() == 0) chk("unexpected_rsp", {8'(m), m_rdata[m]}, '0);
          else chk("rsp_data", {24'h0, 8'(m), m_rdata[m]}, {24'h0, exp_q.pop_front()});
        end
      end
    end
  end

  // Round-robin reference: new grant goes to first requester after the last winner
  int           tb_last = N - 1;
  bit           prev_busy = 0;
  logic [N-1:0] prev_req = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      tb_last   = N - 1;
      prev_busy = 0;
      prev_req  = '0;
    end else begin
      if (busy && !prev_busy) begin
        int win;
        win = -1;
        for (int k = 1; k <= N; k++)
          if (win < 0 && prev_req[(tb_last + k) % N]) win = (tb_last + k) % N;
        if (win < 0) chk("grant_without_req", 64'(grant), 64'h0);
        else begin
          chk("arb_grant", 64'(grant), 64'(1) << win);
          tb_last = win;
          grants_cnt[win]++;
        end
      end
      prev_busy = busy;
      prev_req  = m_read | m_write;
    end
  end

  task automatic do_op(input int m, input bit wr, input logic [15:0] a, input logic [31:0] d,
                       output int acc_cyc, output int rsp_cyc);
    int budget;
    acc_cyc = -1;
    rsp_cyc = -1;
    @(posedge clk); #1;
    m_addr[m]  = a;
    m_wdata[m] = d;
    if (wr) m_write[m] = 1'b1; else m_read[m] = 1'b1;
    budget = 0;
    forever begin
      @(negedge clk);
      if (!m_wait[m]) break;
      if (++budget > 300) begin
        chk("accept_timeout", 64'(m), 64'hFF);
        m_write[m] = 1'b0; m_read[m] = 1'b0;
        return;
      end
    end
    acc_cyc = cyc;
    if (wr) model_mem[a[7:0]] = d;
    else exp_q.push_back({8'(m), slv_drop ? 32'h0 : model_mem[a[7:0]]});
    @(posedge clk); #1;
    m_write[m] = 1'b0; m_read[m] = 1'b0;
    if (!wr) begin
      budget = 0;
      forever begin
        @(negedge clk);
        if (m_rdv[m]) break;
        if (++budget > 300) begin
          chk("rsp_timeout", 64'(m), 64'hFF);
          return;
        end
      end
      rsp_cyc = cyc;
    end
  endtask

  task automatic rand_ops(input int m, input int n, input bit reads_only);
    int a_c, r_c;
    for (int i = 0; i < n; i++) begin
      bit wr;
      wr = reads_only ? 1'b0 : 1'($urandom_range(0, 1));
      do_op(m, wr, 16'(m * 128 + int'($urandom_range(0, 127))), $urandom, a_c, r_c);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, r0, a1, r1, st;
    for (int i = 0; i < 256; i++) begin
      mem[i]       = 32'hA500_0000 | 32'(i);
      model_mem[i] = 32'hA500_0000 | 32'(i);
    end
    for (int m = 0; m < N; m++) begin
      m_addr[m] = '0; m_wdata[m] = '0; grants_cnt[m] = 0;
    end

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_grant", 64'(grant), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_timeout", 64'(timeout), 0);
    chk("rst_mst_wait", 64'(m_wait), 64'h3);
    chk("rst_slv_strobe", {slv_if.read, slv_if.write}, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Directed write with cycle-exact timing
    @(posedge clk); #1;
    m_addr[0] = 16'h0010; m_wdata[0] = 32'h1234_5678; m_write[0] = 1'b1;
    @(negedge clk);
    chk("w_idle_strobe", 64'(slv_if.write), 0);
    @(negedge clk);
    chk("w_strobe", 64'(slv_if.write), 1);
    chk("w_grant", 64'(grant), 64'h1);
    chk("w_mst_wait", 64'(m_wait[0]), 0);
    model_mem[8'h10] = 32'h1234_5678;
    @(posedge clk); #1 m_write[0] = 1'b0;
    @(negedge clk);
    chk("w_back_idle", {grant, busy}, 0);
    chk("w_mem", 64'(mem[8'h10]), 64'h1234_5678);
    do_op(0, 1'b0, 16'h0010, 32'h0, a0, r0);

    // Continuous reads from both masters, latency 3
    slv_lat_min = 3; slv_lat_max = 3;
    grants_cnt[0] = 0; grants_cnt[1] = 0;
    fork
      rand_ops(0, 8, 1'b1);
      rand_ops(1, 8, 1'b1);
    join
    chk("rr_grants_m0", 64'(grants_cnt[0]), 8);
    chk("rr_grants_m1", 64'(grants_cnt[1]), 8);

    // Random mixed traffic
    slv_lat_min = 1; slv_lat_max = 4; slv_stall = 1;
    fork
      rand_ops(0, 12, 1'b0);
      rand_ops(1, 12, 1'b0);
    join

    // Slave stalls master 1 for 5 cycles; master 0 must wait
    slv_stall = 5; st = 0;
    fork
      do_op(1, 1'b1, 16'h0085, 32'hCAFE_0001, a1, r1);
      begin @(posedge clk); do_op(0, 1'b1, 16'h0005, 32'hCAFE_0000, a0, r0); end
      repeat (15) begin @(negedge clk); if (grant == 2'b10 && m_wait[1]) st++; end
    join
    chk("stall_wait_cycles", 64'(st), 5);
    chk("stall_order", 64'(a1 < a0), 1);
    slv_stall = 0;

    // Read timeout, then a stray readdatavalid in IDLE
    slv_drop = 1;
    chk("tmo_none_yet", 64'(tmo_cnt), 0);
    do_op(0, 1'b0, 16'h0020, 32'h0, a0, r0);
    chk("tmo_latency", 64'(r0 - a0), TO);
    @(negedge clk);
    chk("tmo_pulses", 64'(tmo_cnt), 1);
    @(posedge clk); #1 slv_stray = 1'b1;
    @(negedge clk);
    chk("stray_dropped", 64'(m_rdv), 0);
    @(posedge clk); #1 slv_stray = 1'b0;

    // Reset in RD_WAIT
    @(posedge clk); #1 m_addr[1] = 16'h0080; m_read[1] = 1'b1;
    st = 0;
    while (m_wait[1] && st < 50) begin @(negedge clk); st++; end
    @(posedge clk); #1 m_read[1] = 1'b0;
    @(negedge clk);
    chk("pre_rst_busy", 64'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_grant", 64'(grant), 0);
    chk("async_rst_busy", 64'(busy), 0);
    chk("async_rst_strobe", {slv_if.read, slv_if.write}, 0);
    chk("async_rst_wait", 64'(m_wait), 64'h3);
    slv_drop = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    fork
      do_op(1, 1'b1, 16'h0090, 32'h0000_1111, a1, r1);
      do_op(0, 1'b1, 16'h0030, 32'h0000_0000, a0, r0);
    join
    chk("post_rst_m0_first", 64'(a0 < a1), 1);
    do_op(1, 1'b0, 16'h0090, 32'h0, a1, r1);

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", 64'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
